sar_search: RTL and testbench
=============================

# sar_search

Successive-approximation search controller: the driving end of an N-bit magnitude comparator. On `start` it binary-searches the full range 0..2^N-1. Each cycle it presents a trial value on `guess` (the comparator's A input) and consumes the comparator's three flags (B = the unknown target). It reports the matching value, or a failure/error, with a one-cycle `done` pulse. It sits beside the team's N-bit magnitude comparator, for example in threshold-recovery or ADC-style successive-approximation paths.

## Interface
- `N`, default 4: data width; legal range is N ≥ 1.
- `PW`, default $clog2(N+2): width of the probe counter.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a search; sampled only in IDLE.
- `equal`  in  1  comparator flag, guess == target.
- `a_gt_b`  in  1  comparator flag, guess > target.
- `b_gt_a`  in  1  comparator flag, guess < target.
- `guess`  out  N  registered trial value, driven to the comparator A input.
- `busy`  out  1  high while in PROBE.
- `done`  out  1  one-cycle completion pulse.
- `found`  out  1  last search matched; valid from `done`, held until the next accepted start.
- `error`  out  1  last search aborted on illegal flags; held like `found`.
- `result`  out  N  matched value, or 0 if not found; held like `found`.
- `probes`  out  PW  number of probe cycles used by the last search; held like `found`.

## Operation
- States: IDLE, PROBE, DONE.
- Registers: `lo` and `hi` are N+1 bits wide. All arithmetic is unsigned at N+1 bits, so there is no wrap.
- Midpoint: mid = lo + ((hi - lo) >> 1), truncated to N bits for `guess`.
- IDLE with `start`=1:
  - lo ← 0, hi ← 2^N-1, guess ← 2^(N-1)-1 (for N=1, guess ← 0).
  - probes ← 0; found, error and result ← 0.
  - Next state PROBE.
- PROBE: the flags are combinational from `guess` and are sampled every edge. probes increments on each PROBE edge.
  - Flags not exactly one-hot (none set, or more than one set): error ← 1, go to DONE.
  - `equal`: found ← 1, result ← guess, go to DONE.
  - `a_gt_b`: hi ← guess - 1. If guess == 0, go to DONE with found = 0.
  - `b_gt_a`: lo ← guess + 1. If guess == 2^N-1, go to DONE with found = 0.
  - After updating lo/hi: if lo > hi, go to DONE with found = 0. Otherwise guess ← midpoint of the new lo/hi and stay in PROBE.
- DONE: `done` = 1 for exactly this cycle, then unconditional return to IDLE.
- `start` in PROBE or DONE is ignored; it is not queued.
- `guess` holds its last value outside PROBE.
- With a consistent comparator, a search never takes more than N+1 probes. `probes` reaching N+1 without a match also forces DONE with found = 0, as a safety bound.

## Timing
- Reset value of every output is 0: guess, busy, done, found, error, result, probes. State is IDLE.
- Reset overrides everything, including an active search. The search is lost and no `done` is issued.
- Cycle timeline:
  - `start` sampled high at edge e0.
  - PROBE occupies the k cycles that follow; `busy` is high for those k cycles.
  - `done` is high in cycle k+1 after e0.
  - IDLE is reached at edge e0+k+2. A `start` sampled at that edge begins a new search, so back-to-back searches take k+2 cycles each.
- Latency from `start` to `done` is k+1 cycles, where 1 ≤ k ≤ N+1.
- `found`, `error`, `result` and `probes` become valid in the same cycle as `done` and are stable through the following IDLE.

## Structure
- Package `sar_pkg` holds:
  - `sar_state_t`, an enum with IDLE, PROBE, DONE.
  - `cmp_flags_t`, a packed struct {equal, a_gt_b, b_gt_a}.
  - A function `flags_onehot()`.
- One sub-module is natural: `sar_midpoint`, a combinational, N-parameterised block with inputs lo and hi (N+1 bits each) and output mid (N bits).
- The testbench instantiates the team's N-bit magnitude comparator as the target model. A = guess; B = target, driven by the bench.

## Test plan
- N=4, target 5, start pulse → guesses 7, 3, 5. done at cycle 4 after start; found=1, result=5, probes=3.
- N=4, target 15 → guesses 7, 11, 13, 14, 15. probes=5 (N+1); found=1, result=15.
- N=4, target 0 → guesses 7, 3, 1, 0. probes=4; result=0, found=1.
- Flags forced to 000 on the first probe → done next cycle; error=1, found=0, probes=1.
- Reset asserted on the second PROBE cycle → all outputs 0 the next cycle and no done. A new start with target 9 then completes normally with result=9.
- start held high continuously with target 5 → searches repeat every 5 cycles. start is ignored during PROBE and DONE, and results are stable between done pulses.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller.
// Holds the FSM state enum, comparator flag bundle and flag check helper.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } sar_state_t;

    typedef struct packed {
        logic equal;
        logic a_gt_b;
        logic b_gt_a;
    } cmp_flags_t;

    // Exactly one flag set: odd parity rules out 0 and 2 set, the AND rules out 3.
    function automatic logic flags_onehot(input cmp_flags_t f);
        return (f.equal ^ f.a_gt_b ^ f.b_gt_a) &&
               !(f.equal & f.a_gt_b & f.b_gt_a);
    endfunction

endpackage

// File: rtl/sar_midpoint.sv
// Combinational midpoint of an unsigned search interval.
// Ports: lo, hi (N+1 bits) in; mid = lo + ((hi - lo) >> 1), truncated to N bits, out.
module sar_midpoint
    import sar_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N:0]   lo,
    input  logic [N:0]   hi,
    output logic [N-1:0] mid
);

    logic [N:0] span;

    // Only meaningful when lo <= hi; the caller ignores mid otherwise.
    assign span = hi - lo;
    assign mid  = N'(lo + (span >> 1));

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller driving a magnitude comparator.
// Ports: clk, rst, start, equal/a_gt_b/b_gt_a in; guess, busy, done, found, error, result, probes out.
module sar_search
    import sar_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          equal,
    input  logic          a_gt_b,
    input  logic          b_gt_a,
    output logic [N-1:0]  guess,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic          error,
    output logic [N-1:0]  result,
    output logic [PW-1:0] probes
);

    localparam logic [N:0]    HI_INIT = {1'b0, {N{1'b1}}};
    localparam logic [N-1:0]  G_MAX   = {N{1'b1}};
    localparam logic [PW-1:0] P_LIMIT = PW'(N + 1);

    sar_state_t    state_q, state_d;
    logic [N:0]    lo_q, lo_d;
    logic [N:0]    hi_q, hi_d;
    logic [N-1:0]  guess_q, guess_d;
    logic [PW-1:0] probes_q, probes_d;
    logic          found_q, found_d;
    logic          error_q, error_d;
    logic [N-1:0]  result_q, result_d;

    cmp_flags_t    flags;
    logic [N:0]    g_ext;
    logic [N-1:0]  mid;

    assign flags = '{equal: equal, a_gt_b: a_gt_b, b_gt_a: b_gt_a};
    assign g_ext = {1'b0, guess_q};

    // Interval update kept separate so the midpoint sees the new bounds.
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (state_q == IDLE && start) begin
            lo_d = '0;
            hi_d = HI_INIT;
        end else if (state_q == PROBE && flags_onehot(flags)) begin
            if (flags.a_gt_b && guess_q != '0)
                hi_d = g_ext - 1'b1;
            if (flags.b_gt_a && guess_q != G_MAX)
                lo_d = g_ext + 1'b1;
        end
    end

    sar_midpoint #(.N(N)) u_mid (
        .lo  (lo_d),
        .hi  (hi_d),
        .mid (mid)
    );

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        probes_d = probes_q;
        found_d  = found_q;
        error_d  = error_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    guess_d  = mid;
                    probes_d = '0;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    result_d = '0;
                    state_d  = PROBE;
                end
            end
            PROBE: begin
                probes_d = probes_q + PW'(1);
                if (!flags_onehot(flags)) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (flags.equal) begin
                    found_d  = 1'b1;
                    result_d = guess_q;
                    state_d  = DONE;
                end else if (flags.a_gt_b && guess_q == '0) begin
                    state_d = DONE;
                end else if (flags.b_gt_a && guess_q == G_MAX) begin
                    state_d = DONE;
                end else if (lo_d > hi_d) begin
                    state_d = DONE;
                end else if (probes_d == P_LIMIT) begin
                    // Safety bound against an inconsistent comparator.
                    state_d = DONE;
                end else begin
                    guess_d = mid;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            probes_q <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            probes_q <= probes_d;
            found_q  <= found_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    assign guess  = guess_q;
    assign busy   = (state_q == PROBE);
    assign done   = (state_q == DONE);
    assign found  = found_q;
    assign error  = error_q;
    assign result = result_q;
    assign probes = probes_q;

endmodule

// File: tb/tb_sar_search.sv
// Randomized self-checking bench for sar_search.
// Comparator modelled behaviourally; expected guesses from an integer binary search.
module tb_sar_search;

    localparam int N  = 4;
    localparam int PW = $clog2(N + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          equal, a_gt_b, b_gt_a;
    logic [N-1:0]  guess;
    logic          busy, done, found, error;
    logic [N-1:0]  result;
    logic [PW-1:0] probes;

    logic [N-1:0]  target = '0;
    logic          ovr_en = 1'b0;
    logic [2:0]    ovr    = 3'b000;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Target-side magnitude comparator: A = guess, B = target.
    assign equal  = ovr_en ? ovr[2] : (guess == target);
    assign a_gt_b = ovr_en ? ovr[1] : (guess >  target);
    assign b_gt_a = ovr_en ? ovr[0] : (guess <  target);

    sar_search #(.N(N), .PW(PW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .equal  (equal),
        .a_gt_b (a_gt_b),
        .b_gt_a (b_gt_a),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .error  (error),
        .result (result),
        .probes (probes)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Textbook binary search over 0..2^N-1 with integer bounds.
    task automatic model(input int t, output int seq[$]);
        int lo, hi, g;
        seq = {};
        lo = 0;
        hi = (1 << N) - 1;
        while (lo <= hi) begin
            g = (lo + hi) / 2;
            seq.push_back(g);
            if (g == t) break;
            if (g > t) hi = g - 1;
            else       lo = g + 1;
        end
    endtask

    task automatic run_search(input int t);
        int seq[$];
        int cyc;
        model(t, seq);
        @(negedge clk);
        target = N'(t);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < N + 3) begin
            if (cyc < seq.size())
                check("guess", guess, seq[cyc]);
            else
                check("extra_probe", cyc, seq.size());
            cyc++;
            @(negedge clk);
        end
        check("probe_cycles", cyc, seq.size());
        check("done", done, 1);
        check("found", found, 1);
        check("error", error, 0);
        check("result", result, t);
        check("probes", probes, seq.size());
        @(negedge clk);
        check("done_pulse", done, 0);
        check("result_held", result, t);
        check("found_held", found, 1);
    endtask

    task automatic run_bad_flags(input logic [2:0] f);
        @(negedge clk);
        target = N'(3);
        ovr    = f;
        ovr_en = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("bad_busy", busy, 1);
        check("bad_guess", guess, (1 << (N - 1)) - 1);
        @(negedge clk);
        check("bad_done", done, 1);
        check("bad_error", error, 1);
        check("bad_found", found, 0);
        check("bad_probes", probes, 1);
        check("bad_result", result, 0);
        ovr_en = 1'b0;
        @(negedge clk);
        check("bad_idle", busy | done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_guess", guess, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_error", error, 0);
        check("rst_result", result, 0);
        check("rst_probes", probes, 0);
        rst = 1'b0;

        run_search(5);
        run_search(15);
        run_search(0);

        run_bad_flags(3'b000);
        run_bad_flags(3'b110);
        run_bad_flags(3'b111);

        // Reset landing in the second probe cycle.
        @(negedge clk);
        target = N'(9);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_guess", guess, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_probes", probes, 0);
        check("mid_rst_result", result, 0);
        for (int i = 0; i < 4; i++) begin
            check("mid_rst_no_done", done, 0);
            @(negedge clk);
        end
        run_search(9);

        for (int i = 0; i < 24; i++)
            run_search($urandom_range(0, (1 << N) - 1));

        // start held high: k=3 for target 5, so one search every 5 cycles.
        @(negedge clk);
        target = N'(5);
        start  = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check("rep_busy", busy, (c % 5 >= 1 && c % 5 <= 3) ? 1 : 0);
            check("rep_done", done, (c % 5 == 4) ? 1 : 0);
            if (c % 5 == 4 || c % 5 == 0) begin
                check("rep_result", result, 5);
                check("rep_found", found, 1);
            end
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("rep_drain", busy | done, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
